// File: rtl/fp_unpack.sv
// Unpacks an IEEE-754 double or single into sign, signed unbiased exponent,
// explicit-hidden-bit significand and class flags; denormals normalise one bit per cycle.
module fp_unpack #(
  parameter int EW = 13,
  parameter int FW = 53
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [63:0]   op,
  input  logic          db,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          s,
  output logic [EW-1:0] e,
  output logic [FW-1:0] f,
  output logic          zero,
  output logic          inf,
  output logic          nan,
  output logic          snan,
  output logic          denorm
);

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

  state_t                r_state;
  logic                  r_s;
  logic signed [EW-1:0]  r_e;
  logic [FW-1:0]         r_f;
  logic                  r_zero, r_inf, r_nan, r_snan, r_denorm;

  logic [10:0]           w_exp;
  logic [FW-2:0]         w_frac;
  logic                  w_sign;
  logic                  w_e_zero, w_e_max, w_f_zero;
  logic signed [EW-1:0]  w_bias;
  logic signed [EW-1:0]  w_e_unb;
  logic                  w_accept;

  // Single-precision fields are left-aligned so the hidden bit lands at f[FW-1] either way.
  assign w_exp    = db ? op[62:52] : {3'b000, op[30:23]};
  assign w_frac   = db ? op[51:0]  : {op[22:0], 29'd0};
  assign w_sign   = db ? op[63]    : op[31];
  assign w_e_zero = (w_exp == 11'd0);
  assign w_e_max  = db ? (&op[62:52]) : (&op[30:23]);
  assign w_f_zero = (w_frac == '0);
  assign w_bias   = db ? EW'(1023) : EW'(127);
  assign w_e_unb  = $signed(EW'(w_exp)) - w_bias;

  assign in_ready  = (r_state == IDLE) | ((r_state == DONE) & out_ready);
  assign w_accept  = in_valid & in_ready;
  assign out_valid = (r_state == DONE);

  assign s      = r_s;
  assign e      = r_e;
  assign f      = r_f;
  assign zero   = r_zero;
  assign inf    = r_inf;
  assign nan    = r_nan;
  assign snan   = r_snan;
  assign denorm = r_denorm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_s      <= 1'b0;
      r_e      <= '0;
      r_f      <= '0;
      r_zero   <= 1'b0;
      r_inf    <= 1'b0;
      r_nan    <= 1'b0;
      r_snan   <= 1'b0;
      r_denorm <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            r_s      <= w_sign;
            r_zero   <= 1'b0;
            r_inf    <= 1'b0;
            r_nan    <= 1'b0;
            r_snan   <= 1'b0;
            r_denorm <= 1'b0;
            r_state  <= DONE;
            if (w_e_zero && w_f_zero) begin
              r_zero <= 1'b1;
              r_e    <= '0;
              r_f    <= '0;
            end else if (w_e_max) begin
              r_e <= w_bias + EW'(1);
              if (w_f_zero) begin
                r_inf <= 1'b1;
                r_f   <= '0;
              end else begin
                r_nan  <= 1'b1;
                r_snan <= ~w_frac[FW-2];
                r_f    <= {1'b0, w_frac};
              end
            end else if (w_e_zero) begin
              r_denorm <= 1'b1;
              r_e      <= EW'(1) - w_bias;
              r_f      <= {1'b0, w_frac};
              r_state  <= NORM;
            end else begin
              r_e <= w_e_unb;
              r_f <= {1'b1, w_frac};
            end
          end else if (r_state == DONE && out_ready) begin
            r_state <= IDLE;
          end
        end
        NORM: begin
          // Leave on the shift that brings the leading one into the hidden-bit slot.
          r_f <= r_f << 1;
          r_e <= r_e - EW'(1);
          if (r_f[FW-2]) r_state <= DONE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_unpack.sv
// Scoreboard bench for fp_unpack: directed corner cases plus randomized operands
// checked against an arithmetic reference model.
module tb_fp_unpack;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] op = '0;
  logic        db = 1'b1;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        s;
  logic [12:0] e;
  logic [52:0] f;
  logic        zero, inf, nan, snan, denorm;

  always #5 clk = ~clk;

  fp_unpack #(.EW(13), .FW(53)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .db(db), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .e(e), .f(f), .zero(zero), .inf(inf), .nan(nan), .snan(snan),
    .denorm(denorm)
  );

  typedef struct {
    logic        s;
    int          e;
    logic [52:0] f;
    logic [4:0]  fl;   // {zero, inf, nan, snan, denorm}
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic exp_t model(input logic [63:0] o, input logic d);
    exp_t        x;
    int          bias, emax, ex, p;
    logic [52:0] fr;
    bias = d ? 1023 : 127;
    emax = d ? 2047 : 255;
    if (d) begin
      ex = int'(o[62:52]); fr = {1'b0, o[51:0]}; x.s = o[63];
    end else begin
      ex = int'(o[30:23]); fr = {1'b0, o[22:0], 29'd0}; x.s = o[31];
    end
    x.lat = 1;
    x.acc = 0;
    if (ex == 0 && fr == 0) begin
      x.fl = 5'b10000; x.e = 0; x.f = '0;
    end else if (ex == emax) begin
      x.e = bias + 1;
      if (fr == 0) begin
        x.fl = 5'b01000; x.f = '0;
      end else begin
        x.fl = {2'b00, 1'b1, ~fr[51], 1'b0}; x.f = fr;
      end
    end else if (ex == 0) begin
      p = 0;
      for (int i = 0; i < 53; i++) if (fr[i]) p = i;
      x.fl  = 5'b00001;
      x.f   = fr << (52 - p);
      x.e   = 1 - bias - (52 - p);
      x.lat = 1 + (52 - p);
    end else begin
      x.fl = 5'b00000; x.e = ex - bias; x.f = fr | (53'd1 << 52);
    end
    return x;
  endfunction

  function automatic logic [63:0] gen(input logic d);
    logic [63:0] r, x;
    int          c;
    r = {$urandom, $urandom};
    c = $urandom_range(0, 5);
    if (d) begin
      x = {$urandom, $urandom} >> $urandom_range(12, 63);
      case (c)
        0: begin r[62:52] = '0; r[51:0] = '0; end
        1: begin r[62:52] = '0; r[51:0] = (x[51:0] == 0) ? 52'd1 : x[51:0]; end
        2: begin r[62:52] = '1; r[51:0] = '0; end
        3: r[62:52] = '1;
        default: if (r[62:52] == 0 || &r[62:52]) r[62:52] = 11'd1000;
      endcase
    end else begin
      x = {$urandom, $urandom} >> $urandom_range(41, 63);
      case (c)
        0: begin r[30:23] = '0; r[22:0] = '0; end
        1: begin r[30:23] = '0; r[22:0] = (x[22:0] == 0) ? 23'd1 : x[22:0]; end
        2: begin r[30:23] = '1; r[22:0] = '0; end
        3: r[30:23] = '1;
        default: if (r[30:23] == 0 || &r[30:23]) r[30:23] = 8'd100;
      endcase
    end
    return r;
  endfunction

  // Record every operand the DUT will accept on the coming rising edge.
  always @(negedge clk) begin
    exp_t x;
    if (rst_n && in_valid && in_ready) begin
      x = model(op, db);
      x.acc = cyc;
      sb.push_back(x);
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 64'd1, 64'd0);
      end else begin
        if (!seen) begin
          chk("latency", 64'(cyc - sb[0].acc), 64'(sb[0].lat));
          seen = 1'b1;
        end
        if (out_ready) begin
          chk("sign", 64'(s), 64'(sb[0].s));
          chk("exp", 64'($signed(e)), 64'(sb[0].e));
          chk("frac", 64'(f), 64'(sb[0].f));
          chk("flags", 64'({zero, inf, nan, snan, denorm}), 64'(sb[0].fl));
          void'(sb.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  task automatic send(input logic [63:0] o, input logic d);
    int n;
    @(posedge clk); #1;
    in_valid = 1'b1; op = o; db = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_fields", {s, e, f}, 64'd0);
    chk("rst_flags", 64'({zero, inf, nan, snan, denorm}), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    send(64'h3FF0000000000000, 1'b1);
    drain();
    send(64'h0000000000000001, 1'b1);
    repeat (10) begin
      @(negedge clk);
      chk("norm_in_ready", 64'(in_ready), 64'd0);
    end
    drain();
    send(64'h12345678_80000000, 1'b0);
    drain();
    send(64'hFFFFFFFF_00000001, 1'b0);
    drain();
    send(64'h7FF0000000000001, 1'b1);
    drain();

    // Backpressure followed by a same-cycle release and new accept.
    out_ready = 1'b0;
    send(64'h3FF0000000000000, 1'b1);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (5) begin
      @(negedge clk);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_exp", 64'($signed(e)), 64'd0);
      chk("bp_frac", 64'(f), 64'h10000000000000);
    end
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; op = 64'h4000000000000000; db = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("no_bubble", 64'(out_valid), 64'd1);
    drain();

    // Asynchronous reset while a denormal is normalising.
    send(64'h0000000000000001, 1'b1);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    sb.delete();
    seen = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send(64'h3FF8000000000000, 1'b1);
    drain();

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      db        = 1'($urandom_range(0, 1));
      op        = gen(db);
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
